// File: rtl/viterbi_pkg.sv
// Shared constants and helpers for the K=3, rate-1/2 (7,5) convolutional code.
package viterbi_pkg;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  localparam int K          = 3;
  localparam int NUM_STATES = 1 << (K - 1);

  // Start-up metric for every state except 0, so decoding begins anchored at state 0.
  localparam int PM_INIT_UNREACHED = 8;

  // Expected code symbol leaving trellis state {r1, r0} on input bit u.
  function automatic logic [1:0] branch_sym(input logic [1:0] state, input logic u);
    logic [2:0] taps;
    taps = {u, state};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/encoder2.sv
// Rate-1/2 (7,5) convolutional encoder; one code symbol per enabled cycle.
module encoder2
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       valid_o,
  output logic [1:0] d_out
);

  logic [K-2:0] state;  // {r1, r0}, r1 = most recent past bit

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= '0;
      d_out   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= enable_i;
      if (enable_i) begin
        d_out <= branch_sym(state, d_in);
        state <= {d_in, state[1]};
      end
    end
  end

endmodule

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties resolve toward predecessor 0.
module viterbi_acs #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            sel
);

  logic [PM_W:0] cand0;
  logic [PM_W:0] cand1;
  logic [PM_W:0] cand_min;

  // NOTE: every output of this block is assigned on every path, so no latch
  // is inferred.
  always_comb begin
    cand0    = (PM_W + 1)'(pm0) + (PM_W + 1)'(bm0);
    cand1    = (PM_W + 1)'(pm1) + (PM_W + 1)'(bm1);
    sel      = (cand1 < cand0);
    cand_min = sel ? cand1 : cand0;
    pm_new   = cand_min[PM_W] ? {PM_W{1'b1}} : cand_min[PM_W-1:0];
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder for the (7,5) K=3 code.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  logic [PM_W-1:0]     pm        [NUM_STATES];
  logic [TB_DEPTH-1:0] surv      [NUM_STATES];
  logic [PM_W-1:0]     acs_pm    [NUM_STATES];
  logic                acs_sel   [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_next [NUM_STATES];
  logic [PM_W-1:0]     pm_norm   [NUM_STATES];
  logic [PM_W-1:0]     pm_min;
  logic [1:0]          best;

  // State {u, a} is entered from {a, 0} or {a, 1} on input bit u.
  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    localparam logic [1:0] S  = 2'(s);
    localparam logic [1:0] P0 = {S[0], 1'b0};
    localparam logic [1:0] P1 = {S[0], 1'b1};

    logic [1:0]          bm0;
    logic [1:0]          bm1;
    logic [TB_DEPTH-1:0] surv_pred;

    assign bm0 = hamming2(d_in, branch_sym(P0, S[1]));
    assign bm1 = hamming2(d_in, branch_sym(P1, S[1]));

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm0    (pm[P0]),
      .pm1    (pm[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_new (acs_pm[s]),
      .sel    (acs_sel[s])
    );

    assign surv_pred    = acs_sel[s] ? surv[P1] : surv[P0];
    assign surv_next[s] = {surv_pred[TB_DEPTH-2:0], S[1]};
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    pm_min = acs_pm[0];
    best   = 2'd0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (acs_pm[s] < pm_min) begin
        pm_min = acs_pm[s];
        best   = 2'(s);
      end
    end
    for (int s = 0; s < NUM_STATES; s++) begin
      pm_norm[s] = acs_pm[s] - pm_min;
    end
  end

  // NOTE: the survivor registers are reset along with the metrics because the
  // zero-output warm-up after reset depends on them starting clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm[s]   <= (s == 0) ? '0 : PM_W'(PM_INIT_UNREACHED);
        surv[s] <= '0;
      end
      d_out <= 1'b0;
    end else if (enable) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm[s]   <= pm_norm[s];
        surv[s] <= surv_next[s];
      end
      d_out <= surv_next[best][TB_DEPTH-1];
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Encoder -> optional channel error -> decoder bench with directed and looped checks.
module tb_viterbi_decoder;
  import viterbi_pkg::*;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 6;
  localparam int MAXB     = 300;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       enc_en   = 1'b0;
  logic       enc_bit  = 1'b0;
  logic       enc_valid;
  logic [1:0] enc_sym;
  logic [1:0] err_mask = 2'b00;
  logic [1:0] dec_sym;
  logic       dec_out;

  assign dec_sym = enc_sym ^ err_mask;

  always #5 clk = ~clk;

  encoder2 enc (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enc_en),
    .d_in     (enc_bit),
    .valid_o  (enc_valid),
    .d_out    (enc_sym)
  );

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enc_valid),
    .d_in   (dec_sym),
    .d_out  (dec_out)
  );

  int   n_vec = 0;
  int   n_err = 0;
  logic bits [MAXB];
  int   dec_count;
  logic prev_en;
  logic exp_out;

  typedef struct {
    logic       en;
    logic       u;
    logic       valid;
    logic [1:0] sym;
  } enc_vec_t;

  enc_vec_t ev [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pm0"}, 32'(dut.pm[0]), 0);
    check({tag, "_pm1"}, 32'(dut.pm[1]), 8);
    check({tag, "_pm2"}, 32'(dut.pm[2]), 8);
    check({tag, "_pm3"}, 32'(dut.pm[3]), 8);
    check({tag, "_surv"}, 32'(dut.surv[0] | dut.surv[1] | dut.surv[2] | dut.surv[3]), 0);
    check({tag, "_dout"}, 32'(dec_out), 0);
    check({tag, "_enc_valid"}, 32'(enc_valid), 0);
    check({tag, "_enc_sym"}, 32'(enc_sym), 0);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    enc_en = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // One clock: the decoder consumes a symbol iff the encoder was enabled last edge.
  task automatic cycle(input logic en, input logic b, input bit errs, input bit chk_pm0);
    enc_en  = en;
    enc_bit = b;
    if (errs && prev_en && (dec_count % 16 == 5))
      err_mask = ((dec_count / 16) % 2 == 1) ? 2'b01 : 2'b10;
    else
      err_mask = 2'b00;
    tick();
    if (prev_en) begin
      exp_out = (dec_count >= TB_DEPTH - 1) ? bits[dec_count-(TB_DEPTH-1)] : 1'b0;
      dec_count++;
    end
    check("dec_out", 32'(dec_out), 32'(exp_out));
    if (chk_pm0) check("pm0_zero", 32'(dut.pm[0]), 0);
    prev_en = en;
  endtask

  task automatic run_stream(input int n, input bit gaps, input bit errs,
                            input bit chk_pm0, input bit flush);
    dec_count = 0;
    prev_en   = 1'b0;
    exp_out   = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, errs, chk_pm0);
      end
      cycle(1'b1, bits[i], errs, chk_pm0);
    end
    if (flush) cycle(1'b0, 1'b0, errs, chk_pm0);
    err_mask = 2'b00;
  endtask

  initial begin
    ev[0] = '{1'b1, 1'b1, 1'b1, 2'b11};
    ev[1] = '{1'b1, 1'b0, 1'b1, 2'b10};
    ev[2] = '{1'b1, 1'b1, 1'b1, 2'b00};
    ev[3] = '{1'b1, 1'b1, 1'b1, 2'b01};
    ev[4] = '{1'b0, 1'b0, 1'b0, 2'b01};

    do_reset();
    check_reset_state("reset");

    for (int i = 0; i < 5; i++) begin
      enc_en  = ev[i].en;
      enc_bit = ev[i].u;
      tick();
      check($sformatf("enc_valid_%0d", i), 32'(enc_valid), 32'(ev[i].valid));
      check($sformatf("enc_sym_%0d", i), 32'(enc_sym), 32'(ev[i].sym));
    end

    for (int i = 0; i < MAXB; i++) bits[i] = 1'b0;
    do_reset();
    run_stream(48, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < MAXB; i++) bits[i] = 1'($urandom_range(0, 1));
    do_reset();
    run_stream(256 + TB_DEPTH, 1'b0, 1'b0, 1'b0, 1'b1);

    do_reset();
    run_stream(256 + TB_DEPTH, 1'b0, 1'b1, 1'b0, 1'b1);

    do_reset();
    run_stream(256 + TB_DEPTH, 1'b1, 1'b0, 1'b0, 1'b1);

    // Mid-stream reset with enable still high: reset must win.
    do_reset();
    run_stream(100, 1'b0, 1'b0, 1'b0, 1'b0);
    rst     = 1'b0;
    enc_en  = 1'b1;
    enc_bit = 1'b1;
    tick();
    check_reset_state("midreset");
    rst = 1'b1;
    for (int i = 0; i < MAXB; i++) bits[i] = 1'($urandom_range(0, 1));
    run_stream(64 + TB_DEPTH, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
